// File: rtl/intr_pkg.sv
// Shared constants and types for the interrupt arbiter slice.
//   NUM_SRC / ID_W : source count and vector index width
//   CH_IRQ / CH_FIQ: channel indices used for per-channel arrays
//   CFG_MASK / CFG_FIQSEL: cfg_addr decode values
//   ch_state_e: per-channel handshake FSM state
package intr_pkg;
  localparam int NUM_SRC = 8;
  localparam int ID_W    = 3;
  localparam int NUM_CH  = 2;
  localparam int CH_IRQ  = 0;
  localparam int CH_FIQ  = 1;

  localparam logic CFG_MASK   = 1'b0;
  localparam logic CFG_FIQSEL = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_SERVICE = 2'd2
  } ch_state_e;
endpackage

// File: rtl/intr_arbiter_if.sv
// Handshake between the interrupt arbiter and the control FSM.
//   master : control FSM side (drives acknowledges / end-of-interrupt)
//   slave  : arbiter side (drives requests and the granted vector)
interface intr_arbiter_if;
  logic                     INTA_irq;
  logic                     INTA_fiq;
  logic                     eoi_irq;
  logic                     eoi_fiq;
  logic                     INT_irq;
  logic                     INT_fiq;
  logic [intr_pkg::ID_W-1:0] vec_id;
  logic                     vec_valid;
  logic                     vec_fiq;

  modport master (
    output INTA_irq, INTA_fiq, eoi_irq, eoi_fiq,
    input  INT_irq, INT_fiq, vec_id, vec_valid, vec_fiq
  );

  modport slave (
    input  INTA_irq, INTA_fiq, eoi_irq, eoi_fiq,
    output INT_irq, INT_fiq, vec_id, vec_valid, vec_fiq
  );
endinterface

// File: rtl/intr_prio_enc.sv
// Rotating-base priority encoder.
//   req   : request vector
//   base  : index searched first; search wraps upward modulo NUM_SRC
//   idx   : first set request at or after base
//   found : any request set
// A base of 0 gives plain fixed priority with index 0 highest.
module intr_prio_enc
  import intr_pkg::*;
(
  input  logic [NUM_SRC-1:0] req,
  input  logic [ID_W-1:0]    base,
  output logic [ID_W-1:0]    idx,
  output logic               found
);
  logic [ID_W-1:0] k;

  // Walk from the farthest offset down so the nearest hit wins.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    k     = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      k = base + ID_W'(i);
      if (req[k]) begin
        idx   = k;
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/intr_arbiter.sv
// Two-channel (IRQ/FIQ) interrupt arbiter.
//   clk, rst  : clock, asynchronous active-high reset
//   src_req   : raw sources, rising edge latches a pending bit
//   cfg_*     : register write port (addr 0 = mask, 1 = fiq_sel)
//   pending   : pending register view
//   bus       : slave side of the control-FSM handshake
// Build option: define INTR_RR_EN for rotating priority on the IRQ
// channel; FIQ always uses fixed priority.
module intr_arbiter
  import intr_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] src_req,
  input  logic               cfg_we,
  input  logic               cfg_addr,
  input  logic [NUM_SRC-1:0] cfg_wdata,
  output logic [NUM_SRC-1:0] pending,
  intr_arbiter_if.slave      bus
);
  logic [NUM_SRC-1:0] src_prev, mask, fiq_sel, rise, clr;
  logic [NUM_CH-1:0][NUM_SRC-1:0] elig;
  logic [NUM_CH-1:0][ID_W-1:0]    base, gnt_id;
  logic [NUM_CH-1:0]              found, inta, eoi, grant, int_r;
  ch_state_e                      state [NUM_CH];
  logic                           hold_vld;
  logic [ID_W-1:0]                hold_id;

  assign rise = src_req & ~src_prev;
  assign elig[CH_IRQ] = pending & ~mask & ~fiq_sel;
  assign elig[CH_FIQ] = pending & ~mask &  fiq_sel;

  assign inta = {bus.INTA_fiq, bus.INTA_irq};
  assign eoi  = {bus.eoi_fiq,  bus.eoi_irq};

`ifdef INTR_RR_EN
  logic [ID_W-1:0] rr_base;
  // Next search starts just past the last IRQ grant.
  always_ff @(posedge clk or posedge rst)
    if (rst)               rr_base <= '0;
    else if (grant[CH_IRQ]) rr_base <= gnt_id[CH_IRQ] + ID_W'(1);
  assign base[CH_IRQ] = rr_base;
`else
  assign base[CH_IRQ] = '0;
`endif
  assign base[CH_FIQ] = '0;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    intr_prio_enc u_enc (
      .req   (elig[c]),
      .base  (base[c]),
      .idx   (gnt_id[c]),
      .found (found[c])
    );
    assign grant[c] = (state[c] == ST_ASSERT) && inta[c] && found[c];
  end

  always_comb begin
    clr = '0;
    for (int c = 0; c < NUM_CH; c++)
      if (grant[c]) clr[gnt_id[c]] = 1'b1;
  end

  // Source sampling, pending (new rise wins over grant clear) and config.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      src_prev <= '0;
      pending  <= '0;
      mask     <= '1;
      fiq_sel  <= '0;
    end else begin
      src_prev <= src_req;
      pending  <= (pending & ~clr) | rise;
      if (cfg_we) begin
        if (cfg_addr == CFG_MASK) mask    <= cfg_wdata;
        else                      fiq_sel <= cfg_wdata;
      end
    end

  // Per-channel handshake FSM; int_r tracks ASSERT as a registered output.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) state[c] <= ST_IDLE;
      int_r <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        case (state[c])
          ST_IDLE:
            if (|elig[c]) begin
              state[c] <= ST_ASSERT;
              int_r[c] <= 1'b1;
            end
          ST_ASSERT:
            if (grant[c]) begin
              state[c] <= ST_SERVICE;
              int_r[c] <= 1'b0;
            end else if (!found[c]) begin
              state[c] <= ST_IDLE;
              int_r[c] <= 1'b0;
            end
          ST_SERVICE:
            if (eoi[c]) state[c] <= ST_IDLE;
          default: begin
            state[c] <= ST_IDLE;
            int_r[c] <= 1'b0;
          end
        endcase
      end
    end

  // Vector port. A simultaneous grant reports FIQ first and parks the IRQ
  // index for one cycle. While parked, IRQ is in SERVICE and FIQ has just
  // entered SERVICE, so no other grant can collide with the replay.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bus.vec_valid <= 1'b0;
      bus.vec_id    <= '0;
      bus.vec_fiq   <= 1'b0;
      hold_vld      <= 1'b0;
      hold_id       <= '0;
    end else begin
      bus.vec_valid <= 1'b0;
      if (hold_vld) begin
        bus.vec_valid <= 1'b1;
        bus.vec_id    <= hold_id;
        bus.vec_fiq   <= 1'b0;
        hold_vld      <= 1'b0;
      end else if (grant[CH_FIQ]) begin
        bus.vec_valid <= 1'b1;
        bus.vec_id    <= gnt_id[CH_FIQ];
        bus.vec_fiq   <= 1'b1;
        hold_vld      <= grant[CH_IRQ];
        hold_id       <= gnt_id[CH_IRQ];
      end else if (grant[CH_IRQ]) begin
        bus.vec_valid <= 1'b1;
        bus.vec_id    <= gnt_id[CH_IRQ];
        bus.vec_fiq   <= 1'b0;
      end
    end

  assign bus.INT_irq = int_r[CH_IRQ];
  assign bus.INT_fiq = int_r[CH_FIQ];
endmodule

// File: tb/tb_intr_arbiter.sv
module tb_intr_arbiter;
  import intr_pkg::*;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic            fiq;
  } vexp_t;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [NUM_SRC-1:0] src_req = '0;
  logic               cfg_we = 1'b0;
  logic               cfg_addr = 1'b0;
  logic [NUM_SRC-1:0] cfg_wdata = '0;
  logic [NUM_SRC-1:0] pending;
  intr_arbiter_if     bus();

  int    total = 0;
  int    bad   = 0;
  vexp_t exp_q[$];

  intr_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .src_req   (src_req),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .pending   (pending),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Scoreboard consumer: every vector pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (bus.vec_valid === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL vec_unexpected got id=%0d fiq=%0d expected none",
                 bus.vec_id, bus.vec_fiq);
      end else begin
        vexp_t e;
        e = exp_q.pop_front();
        if ({bus.vec_id, bus.vec_fiq} !== {e.id, e.fiq}) begin
          bad++;
          $display("FAIL vec_match got id=%0d fiq=%0d expected id=%0d fiq=%0d",
                   bus.vec_id, bus.vec_fiq, e.id, e.fiq);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input int id, input logic fiq);
    vexp_t e;
    e.id  = ID_W'(id);
    e.fiq = fiq;
    exp_q.push_back(e);
  endtask

  task automatic cfg_write(input logic a, input logic [NUM_SRC-1:0] d);
    cfg_addr = a; cfg_wdata = d; cfg_we = 1'b1;
    cyc(1);
    cfg_we = 1'b0;
  endtask

  task automatic ack(input logic i, input logic f);
    bus.INTA_irq = i; bus.INTA_fiq = f;
    cyc(1);
    bus.INTA_irq = 1'b0; bus.INTA_fiq = 1'b0;
  endtask

  task automatic eoi(input logic i, input logic f);
    bus.eoi_irq = i; bus.eoi_fiq = f;
    cyc(1);
    bus.eoi_irq = 1'b0; bus.eoi_fiq = 1'b0;
  endtask

  task automatic do_reset();
    cyc(1);
    rst = 1'b1; src_req = '0;
    cyc(2);
    rst = 1'b0;
    cyc(1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(2);
    total++; if (bus.INT_irq !== 1'b0) begin bad++; $display("FAIL rst_int_irq got %b expected 0", bus.INT_irq); end
    total++; if (bus.INT_fiq !== 1'b0) begin bad++; $display("FAIL rst_int_fiq got %b expected 0", bus.INT_fiq); end
    total++; if (bus.vec_valid !== 1'b0) begin bad++; $display("FAIL rst_vec_valid got %b expected 0", bus.vec_valid); end
    total++; if (bus.vec_id !== 3'd0) begin bad++; $display("FAIL rst_vec_id got %0d expected 0", bus.vec_id); end
    total++; if (bus.vec_fiq !== 1'b0) begin bad++; $display("FAIL rst_vec_fiq got %b expected 0", bus.vec_fiq); end
    total++; if (pending !== 8'h00) begin bad++; $display("FAIL rst_pending got %h expected 00", pending); end
    rst = 1'b0;
    // Reset mask is all ones: a rise pends but never requests.
    src_req[0] = 1'b1;
    cyc(4);
    total++; if (pending !== 8'h01) begin bad++; $display("FAIL rst_mask_pending got %h expected 01", pending); end
    total++; if (bus.INT_irq !== 1'b0) begin bad++; $display("FAIL rst_mask_int got %b expected 0", bus.INT_irq); end
    do_reset();
  endtask

  task automatic test_basic();
    cfg_write(CFG_MASK, 8'h00);
    src_req[5] = 1'b1;
    cyc(1);
    total++; if (bus.INT_irq !== 1'b0) begin bad++; $display("FAIL basic_int_n1 got %b expected 0", bus.INT_irq); end
    cyc(1);
    total++; if (bus.INT_irq !== 1'b1) begin bad++; $display("FAIL basic_int_n2 got %b expected 1", bus.INT_irq); end
    push(5, 1'b0);
    ack(1'b1, 1'b0);
    total++; if (pending[5] !== 1'b0) begin bad++; $display("FAIL basic_pend_clr got %b expected 0", pending[5]); end
    total++; if (bus.INT_irq !== 1'b0) begin bad++; $display("FAIL basic_int_service got %b expected 0", bus.INT_irq); end
    eoi(1'b1, 1'b0);
    cyc(2);
    total++; if (bus.INT_irq !== 1'b0) begin bad++; $display("FAIL basic_idle got %b expected 0", bus.INT_irq); end
    do_reset();
  endtask

  task automatic test_priority();
    cfg_write(CFG_MASK, 8'h00);
    src_req = 8'b0010_0100;
    cyc(2);
    total++; if (bus.INT_irq !== 1'b1) begin bad++; $display("FAIL prio_int got %b expected 1", bus.INT_irq); end
    push(2, 1'b0);
    ack(1'b1, 1'b0);
    total++; if (pending !== 8'b0010_0000) begin bad++; $display("FAIL prio_pend1 got %b expected 00100000", pending); end
    eoi(1'b1, 1'b0);
    cyc(1);
    total++; if (bus.INT_irq !== 1'b1) begin bad++; $display("FAIL prio_reassert got %b expected 1", bus.INT_irq); end
    push(5, 1'b0);
    ack(1'b1, 1'b0);
    total++; if (pending !== 8'h00) begin bad++; $display("FAIL prio_pend2 got %h expected 00", pending); end
    eoi(1'b1, 1'b0);
    do_reset();
  endtask

  task automatic test_fiq_independent();
    cfg_write(CFG_MASK, 8'h00);
    cfg_write(CFG_FIQSEL, 8'h80);
    src_req[1] = 1'b1;
    cyc(2);
    push(1, 1'b0);
    ack(1'b1, 1'b0);
    src_req[7] = 1'b1;
    cyc(2);
    total++; if (bus.INT_fiq !== 1'b1) begin bad++; $display("FAIL fiq_int got %b expected 1", bus.INT_fiq); end
    total++; if (bus.INT_irq !== 1'b0) begin bad++; $display("FAIL fiq_irq_quiet got %b expected 0", bus.INT_irq); end
    push(7, 1'b1);
    ack(1'b0, 1'b1);
    total++; if (pending !== 8'h00) begin bad++; $display("FAIL fiq_pend got %h expected 00", pending); end
    // IRQ still in SERVICE: a stray acknowledge is ignored, new pend waits.
    ack(1'b1, 1'b0);
    src_req[2] = 1'b1;
    cyc(3);
    total++; if (bus.INT_irq !== 1'b0) begin bad++; $display("FAIL fiq_irq_nonest got %b expected 0", bus.INT_irq); end
    eoi(1'b1, 1'b0);
    cyc(1);
    total++; if (bus.INT_irq !== 1'b1) begin bad++; $display("FAIL fiq_irq_after_eoi got %b expected 1", bus.INT_irq); end
    push(2, 1'b0);
    ack(1'b1, 1'b0);
    eoi(1'b1, 1'b1);
    do_reset();
  endtask

  task automatic test_mask();
    cfg_write(CFG_MASK, 8'h00);
    src_req[3] = 1'b1;
    cyc(2);
    total++; if (bus.INT_irq !== 1'b1) begin bad++; $display("FAIL mask_int got %b expected 1", bus.INT_irq); end
    cfg_write(CFG_MASK, 8'hFF);
    cyc(1);
    total++; if (bus.INT_irq !== 1'b0) begin bad++; $display("FAIL mask_drop got %b expected 0", bus.INT_irq); end
    total++; if (pending !== 8'h08) begin bad++; $display("FAIL mask_keep_pend got %h expected 08", pending); end
    cfg_write(CFG_MASK, 8'h00);
    cyc(1);
    total++; if (bus.INT_irq !== 1'b1) begin bad++; $display("FAIL mask_reassert got %b expected 1", bus.INT_irq); end
    push(3, 1'b0);
    ack(1'b1, 1'b0);
    eoi(1'b1, 1'b0);
    do_reset();
  endtask

  task automatic test_simultaneous();
    cfg_write(CFG_MASK, 8'h00);
    cfg_write(CFG_FIQSEL, 8'h01);
    src_req = 8'h03;
    cyc(2);
    total++; if ({bus.INT_fiq, bus.INT_irq} !== 2'b11) begin bad++; $display("FAIL simul_ints got %b expected 11", {bus.INT_fiq, bus.INT_irq}); end
    push(0, 1'b1);
    push(1, 1'b0);
    ack(1'b1, 1'b1);
    total++; if (pending !== 8'h00) begin bad++; $display("FAIL simul_pend got %h expected 00", pending); end
    cyc(2);
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL simul_drain got %0d left expected 0", exp_q.size()); end
    eoi(1'b1, 1'b1);
    do_reset();
  endtask

  task automatic test_back_to_back();
    cfg_write(CFG_MASK, 8'h00);
    src_req[4] = 1'b1;
    cyc(1);
    src_req[4] = 1'b0;
    cyc(1);
    total++; if (bus.INT_irq !== 1'b1) begin bad++; $display("FAIL b2b_int got %b expected 1", bus.INT_irq); end
    // New rise lands in the acknowledge cycle: it must survive the clear.
    push(4, 1'b0);
    bus.INTA_irq = 1'b1; src_req[4] = 1'b1;
    cyc(1);
    bus.INTA_irq = 1'b0;
    total++; if (pending[4] !== 1'b1) begin bad++; $display("FAIL b2b_set_wins got %b expected 1", pending[4]); end
    eoi(1'b1, 1'b0);
    cyc(1);
    total++; if (bus.INT_irq !== 1'b1) begin bad++; $display("FAIL b2b_reassert got %b expected 1", bus.INT_irq); end
    push(4, 1'b0);
    ack(1'b1, 1'b0);
    eoi(1'b1, 1'b0);
    do_reset();
  endtask

  task automatic test_rotate();
    int seq [4];
`ifdef INTR_RR_EN
    seq = '{0, 1, 0, 1};
`else
    seq = '{0, 0, 0, 0};
`endif
    cfg_write(CFG_MASK, 8'h00);
    src_req = 8'h03;
    cyc(2);
    for (int r = 0; r < 4; r++) begin
      total++; if (bus.INT_irq !== 1'b1) begin bad++; $display("FAIL rr_int round=%0d got %b expected 1", r, bus.INT_irq); end
      push(seq[r], 1'b0);
      ack(1'b1, 1'b0);
      // Re-pend the granted source so 8'h03 stays pending.
      src_req[seq[r]] = 1'b0;
      cyc(1);
      src_req[seq[r]] = 1'b1;
      cyc(1);
      eoi(1'b1, 1'b0);
      cyc(1);
    end
    do_reset();
  endtask

  task automatic test_reset_mid_service();
    cfg_write(CFG_MASK, 8'h00);
    src_req[6] = 1'b1;
    cyc(2);
    push(6, 1'b0);
    ack(1'b1, 1'b0);
    cyc(1);
    rst = 1'b1; src_req = '0;
    cyc(2);
    rst = 1'b0;
    ack(1'b1, 1'b0);
    eoi(1'b1, 1'b0);
    cyc(3);
    total++; if (bus.INT_irq !== 1'b0) begin bad++; $display("FAIL rstsvc_int got %b expected 0", bus.INT_irq); end
    total++; if (pending !== 8'h00) begin bad++; $display("FAIL rstsvc_pend got %h expected 00", pending); end
  endtask

  initial begin
    bus.INTA_irq = 1'b0; bus.INTA_fiq = 1'b0;
    bus.eoi_irq  = 1'b0; bus.eoi_fiq  = 1'b0;
    test_reset();
    test_basic();
    test_priority();
    test_fiq_independent();
    test_mask();
    test_simultaneous();
    test_back_to_back();
    test_rotate();
    test_reset_mid_service();
    cyc(2);
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL final_drain got %0d left expected 0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
